lfsr_step_ctrl: RTL and testbench

Step and seed controller that sits directly upstream of the 4-bit XNOR-feedback LFSR and 7-segment decoder stage. It turns two raw push-buttons and a run switch into clean, single-cycle `step` and `load` strobes plus a validated seed. The LFSR then advances visibly, either free-running at a prescaled rate or one state per button press. It also guarantees the LFSR is never loaded with its all-ones lockup state.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/btn_conditioner.sv | 66 ++++++
 rtl/lfsr_step_ctrl.sv | 124 ++++++++++++
 tb/tb_lfsr_step_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the 4-bit XNOR LFSR step/seed front end.
package lfsr_pkg;

    localparam int LFSR_W      = 4;
    localparam int SYNC_STAGES = 2;

    localparam logic [LFSR_W-1:0] LOCKUP_SEED = 4'hF;
    localparam logic [LFSR_W-1:0] SAFE_SEED   = 4'h0;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } step_state_t;

    // An XNOR LFSR loaded with all ones never leaves that state.
    function automatic logic [LFSR_W-1:0] sanitize_seed(input logic [LFSR_W-1:0] seed);
        return (seed == LOCKUP_SEED) ? SAFE_SEED : seed;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button to single-cycle press pulse: synchronizer, debouncer and
// rising-edge detector.
module btn_conditioner
    import lfsr_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   level_reg, level_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   press_reg, press_next;
    logic                   btn_sync;

    assign btn_sync = sync_reg[SYNC_STAGES-1];
    assign press    = press_reg;

    // The synchronizer keeps sampling even while the design is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
        end
    end

    always_comb begin
        level_next = level_reg;
        cnt_next   = cnt_reg;
        press_next = 1'b0;
        if (ena) begin
            if (btn_sync == level_reg) begin
                cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Acceptance and the rising-edge pulse happen on the same edge.
                level_next = btn_sync;
                cnt_next   = '0;
                press_next = btn_sync;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= 1'b0;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
            press_reg <= press_next;
        end
    end

endmodule

// File: rtl/lfsr_step_ctrl.sv
// Step/load strobe generator and seed sanitizer feeding the XNOR LFSR:
// RUN free-runs at PRESCALE cycles per step, STOP steps once per button press.
module lfsr_step_ctrl
    import lfsr_pkg::*;
#(
    parameter int PRESCALE     = 1_000_000,
    parameter int DEBOUNCE_CNT = 50_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              run_sw,
    input  logic              step_btn,
    input  logic              load_btn,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              step,
    output logic              load,
    output logic [LFSR_W-1:0] seed_q,
    output logic              running
);

    localparam int PRE_W = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    localparam int BTN_STEP = 0;
    localparam int BTN_LOAD = 1;
    localparam int NUM_BTN  = 2;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;

    assign btn_raw = {load_btn, step_btn};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_conditioner #(
                .DEBOUNCE_CNT(DEBOUNCE_CNT)
            ) u_cond (
                .clk    (clk),
                .rst_n  (rst_n),
                .ena    (ena),
                .btn_raw(btn_raw[gi]),
                .press  (btn_press[gi])
            );
        end
    endgenerate

    logic [SYNC_STAGES-1:0] run_sync_reg;
    logic                   run_req_reg;

    // run_req_reg retimes the synchronized switch so the state register, and
    // with it running, moves three edges after the switch is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_sync_reg <= '0;
            run_req_reg  <= 1'b0;
        end else begin
            run_sync_reg <= {run_sync_reg[SYNC_STAGES-2:0], run_sw};
            run_req_reg  <= run_sync_reg[SYNC_STAGES-1];
        end
    end

    step_state_t       state_reg, state_next;
    logic [PRE_W-1:0]  pre_reg, pre_next;
    logic              step_reg, step_next;
    logic              load_reg, load_next;
    logic [LFSR_W-1:0] seed_reg, seed_next;
    logic              step_evt;
    logic              pre_clear;

    always_comb begin
        state_next = state_reg;
        pre_next   = pre_reg;
        step_next  = 1'b0;
        load_next  = 1'b0;
        seed_next  = seed_reg;
        step_evt   = 1'b0;
        pre_clear  = 1'b0;
        if (ena) begin
            case (state_reg)
                STOP:    if (run_req_reg)  state_next = RUN;
                RUN:     if (!run_req_reg) state_next = STOP;
                default: state_next = STOP;
            endcase

            step_evt = (state_reg == RUN) ? (pre_reg == PRE_LAST) : btn_press[BTN_STEP];

            // A load always beats a step landing in the same cycle.
            if (btn_press[BTN_LOAD]) begin
                load_next = 1'b1;
                seed_next = sanitize_seed(seed_in);
            end else begin
                step_next = step_evt;
            end

            pre_clear = (state_next != state_reg) || btn_press[BTN_LOAD] ||
                        (state_reg == STOP) || (pre_reg == PRE_LAST);
            pre_next  = pre_clear ? '0 : pre_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= STOP;
            pre_reg   <= '0;
            step_reg  <= 1'b0;
            load_reg  <= 1'b0;
            seed_reg  <= SAFE_SEED;
        end else begin
            state_reg <= state_next;
            pre_reg   <= pre_next;
            step_reg  <= step_next;
            load_reg  <= load_next;
            seed_reg  <= seed_next;
        end
    end

    assign step    = step_reg;
    assign load    = load_reg;
    assign seed_q  = seed_reg;
    assign running = (state_reg == RUN);

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Directed bench for lfsr_step_ctrl with PRESCALE=4, DEBOUNCE_CNT=3.
module tb_lfsr_step_ctrl;

    localparam int PRESCALE     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ena      = 1'b1;
    logic       run_sw   = 1'b0;
    logic       step_btn = 1'b0;
    logic       load_btn = 1'b0;
    logic [3:0] seed_in  = 4'h0;
    logic       step;
    logic       load;
    logic [3:0] seed_q;
    logic       running;

    int checks   = 0;
    int errors   = 0;
    int both_cnt = 0;

    lfsr_step_ctrl #(
        .PRESCALE    (PRESCALE),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .run_sw  (run_sw),
        .step_btn(step_btn),
        .load_btn(load_btn),
        .seed_in (seed_in),
        .step    (step),
        .load    (load),
        .seed_q  (seed_q),
        .running (running)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step === 1'b1 && load === 1'b1) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_step(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (step === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_load(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (load === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_running(input logic val, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (running === val) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        int cnt;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step); end
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", load); end
        checks++; if (seed_q !== 4'h0) begin errors++; $display("FAIL reset_seed: got %h expected 0", seed_q); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
        $display("[reset] initial outputs step=%b load=%b seed_q=%h running=%b", step, load, seed_q, running);

        rst_n    = 1'b1;
        run_sw   = 1'b1;
        load_btn = 1'b1;
        seed_in  = 4'h5;
        wait_load(20, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL reset_preload_latency: got %0d expected 6", lat); end
        checks++; if (seed_q !== 4'h5) begin errors++; $display("FAIL reset_preload_seed: got %h expected 5", seed_q); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL reset_prerun: got %b expected 1", running); end
        load_btn = 1'b0;
        step_btn = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_async_running: got %b expected 0", running); end
        checks++; if (seed_q !== 4'h0) begin errors++; $display("FAIL reset_async_seed: got %h expected 0", seed_q); end
        checks++; if (step !== 1'b0 || load !== 1'b0) begin errors++; $display("FAIL reset_async_strobes: got step=%b load=%b expected 0 0", step, load); end
        $display("[reset] async assert running=%b seed_q=%h", running, seed_q);
        run_sw = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wait_step(20, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL reset_fresh_window: got %0d expected 6", lat); end
        $display("[reset] step after release latency=%0d", lat);
        step_btn = 1'b0;
        cnt = 0;
        repeat (10) begin tick(); if (step === 1'b1) cnt++; end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL reset_release_steps: got %0d expected 0", cnt); end
    endtask

    task automatic test_bounce();
        int lat;
        int cnt;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step_btn = (i % 2 == 0);
            tick();
            if (step === 1'b1) cnt++;
        end
        step_btn = 1'b1;
        wait_step(20, lat);
        checks++; if (cnt !== 0) begin errors++; $display("FAIL bounce_glitch_steps: got %0d expected 0", cnt); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL bounce_latency: got %0d expected 6", lat); end
        cnt = 0;
        repeat (4) begin tick(); if (step === 1'b1) cnt++; end
        step_btn = 1'b0;
        repeat (10) begin tick(); if (step === 1'b1) cnt++; end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL bounce_extra_steps: got %0d expected 0", cnt); end
        $display("[bounce] step latency=%0d extra=%0d", lat, cnt);
    endtask

    task automatic test_run_cadence();
        int lat;
        int fall;
        logic [63:0] smask;
        logic [63:0] exp_s;
        smask = '0;
        exp_s = '0;
        exp_s[4]  = 1'b1;
        exp_s[8]  = 1'b1;
        exp_s[12] = 1'b1;
        fall = -1;
        run_sw = 1'b1;
        wait_running(1'b1, 10, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL run_enter_latency: got %0d expected 4", lat); end
        step_btn = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            if (t == 8)  step_btn = 1'b0;
            if (t == 10) run_sw = 1'b0;
            tick();
            if (step === 1'b1) smask[t] = 1'b1;
            if (running === 1'b0 && fall < 0) fall = t;
        end
        checks++; if (smask !== exp_s) begin errors++; $display("FAIL run_cadence: got %h expected %h", smask, exp_s); end
        checks++; if (fall !== 13) begin errors++; $display("FAIL run_exit_latency: got %0d expected 13", fall); end
        $display("[run] enter=%0d step_mask=%h exit=%0d", lat, smask, fall);
    endtask

    task automatic test_seed();
        int lat;
        seed_in  = 4'hF;
        load_btn = 1'b1;
        wait_load(20, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL seed_lockup_latency: got %0d expected 6", lat); end
        checks++; if (seed_q !== 4'h0) begin errors++; $display("FAIL seed_lockup_value: got %h expected 0", seed_q); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL seed_lockup_step: got %b expected 0", step); end
        tick();
        checks++; if (load !== 1'b0 || seed_q !== 4'h0) begin errors++; $display("FAIL seed_single_pulse: got load=%b seed_q=%h expected 0 0", load, seed_q); end
        $display("[seed] seed_in=F seed_q=%h", seed_q);
        load_btn = 1'b0;
        repeat (8) tick();
        seed_in  = 4'h9;
        load_btn = 1'b1;
        wait_load(20, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL seed_nine_latency: got %0d expected 6", lat); end
        checks++; if (seed_q !== 4'h9) begin errors++; $display("FAIL seed_nine_value: got %h expected 9", seed_q); end
        seed_in = 4'h3;
        tick();
        tick();
        checks++; if (seed_q !== 4'h9) begin errors++; $display("FAIL seed_hold: got %h expected 9", seed_q); end
        $display("[seed] seed_in=9 seed_q=%h", seed_q);
        load_btn = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_collision();
        logic [63:0] smask;
        logic [63:0] lmask;
        logic [63:0] exp_s;
        logic [63:0] exp_l;
        logic [3:0]  seed_mid;
        smask = '0;
        lmask = '0;
        exp_s = '0;
        exp_l = '0;
        exp_s[12] = 1'b1;
        exp_s[16] = 1'b1;
        exp_s[20] = 1'b1;
        exp_s[24] = 1'b1;
        exp_s[30] = 1'b1;
        exp_s[34] = 1'b1;
        exp_l[8]  = 1'b1;
        exp_l[26] = 1'b1;
        seed_mid  = 4'hX;
        for (int t = 1; t <= 40; t++) begin
            if (t == 1)  run_sw = 1'b1;
            if (t == 3)  begin load_btn = 1'b1; seed_in = 4'hA; end
            if (t == 10) load_btn = 1'b0;
            if (t == 21) begin load_btn = 1'b1; seed_in = 4'hF; end
            if (t == 28) load_btn = 1'b0;
            if (t == 32) run_sw = 1'b0;
            tick();
            if (step === 1'b1) smask[t] = 1'b1;
            if (load === 1'b1) lmask[t] = 1'b1;
            if (t == 8) seed_mid = seed_q;
        end
        checks++; if (lmask !== exp_l) begin errors++; $display("FAIL collision_loads: got %h expected %h", lmask, exp_l); end
        checks++; if (smask !== exp_s) begin errors++; $display("FAIL collision_steps: got %h expected %h", smask, exp_s); end
        checks++; if (seed_mid !== 4'hA) begin errors++; $display("FAIL collision_seed: got %h expected a", seed_mid); end
        checks++; if (seed_q !== 4'h0) begin errors++; $display("FAIL collision_run_lockup: got %h expected 0", seed_q); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL collision_stop: got %b expected 0", running); end
        $display("[collision] load_mask=%h step_mask=%h", lmask, smask);
    endtask

    task automatic test_enable();
        int cnt;
        int lat;
        cnt = 0;
        for (int t = 1; t <= 20; t++) begin
            if (t == 1)  step_btn = 1'b1;
            if (t == 6)  ena = 1'b0;
            if (t == 10) ena = 1'b1;
            if (t == 12) step_btn = 1'b0;
            tick();
            if (step === 1'b1 || load === 1'b1) cnt++;
        end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL enable_dropped: got %0d strobes expected 0", cnt); end
        $display("[enable] strobes with press during ena=0: %0d", cnt);
        step_btn = 1'b1;
        wait_step(20, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL enable_normal_press: got %0d expected 6", lat); end
        step_btn = 1'b0;
        repeat (8) tick();
        ena    = 1'b0;
        run_sw = 1'b1;
        repeat (8) tick();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL enable_fsm_hold: got %b expected 0", running); end
        ena = 1'b1;
        wait_running(1'b1, 10, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL enable_fsm_resume: got %0d expected 1", lat); end
        run_sw = 1'b0;
        wait_running(1'b0, 10, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL enable_fsm_exit: got %0d expected 4", lat); end
        $display("[enable] fsm resume/exit done");
    endtask

    task automatic test_invariant();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL invariant_step_load: got %0d overlaps expected 0", both_cnt); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_bounce();
        test_run_cadence();
        test_seed();
        test_collision();
        test_enable();
        test_invariant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
